// File: rtl/alu_exec_unit_if.sv
// Operand/opcode request bus and result/flag bus of the ALU execute stage.
interface alu_exec_unit_if;
    logic [7:0] aBus;
    logic [7:0] bBusMUX;
    logic [3:0] aluOp;
    logic       start;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [7:0] result;
    logic [7:0] resultHi;
    logic       flagZ;
    logic       flagN;
    logic       flagC;
    logic       flagV;

    modport master (
        output aBus, bBusMUX, aluOp, start,
        input  busy, done, illegal, result, resultHi,
        input  flagZ, flagN, flagC, flagV
    );

    modport slave (
        input  aBus, bBusMUX, aluOp, start,
        output busy, done, illegal, result, resultHi,
        output flagZ, flagN, flagC, flagV
    );
endinterface

// File: rtl/alu_exec_unit.sv
// 8-bit ALU execute stage: single-cycle ops plus an 8-step
// shift-add unsigned multiply, with registered result and Z/N/C/V flags.
module alu_exec_unit #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_PSB = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_ASR = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;
    localparam logic [3:0] OP_INC = 4'hC;
    localparam logic [3:0] OP_DEC = 4'hD;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               state_q;
    logic                 busy_q, done_q, illegal_q;
    logic [WIDTH-1:0]     res_q, hi_q;
    logic                 z_q, n_q, c_q, v_q;
    logic [2*WIDTH-1:0]   acc_q, mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2:0]           cnt_q;

    logic [WIDTH-1:0]     a, b, add_b, sub_b;
    logic [WIDTH:0]       sum, dif;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v, wr_res, legal;
    logic [2*WIDTH-1:0]   acc_d;

    assign a     = bus.aBus;
    assign b     = bus.bBusMUX;
    assign add_b = (bus.aluOp == OP_INC) ? 8'h01 : b;
    assign sub_b = (bus.aluOp == OP_DEC) ? 8'h01 : b;
    assign sum   = {1'b0, a} + {1'b0, add_b};
    assign dif   = {1'b0, a} - {1'b0, sub_b};

    // One shift-add step: multiplicand shifts left, multiplier right
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

    always_comb begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        wr_res  = 1'b1;
        legal   = 1'b1;
        unique case (bus.aluOp)
            OP_ADD, OP_INC: begin
                alu_res = sum[7:0];
                alu_c   = sum[8];
                alu_v   = (a[7] == add_b[7]) && (sum[7] != a[7]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                alu_res = dif[7:0];
                alu_c   = dif[8];
                alu_v   = (a[7] != sub_b[7]) && (dif[7] != a[7]);
                wr_res  = (bus.aluOp != OP_CMP);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_PSB: alu_res = b;
            OP_SHL: begin
                alu_res = {a[6:0], 1'b0};
                alu_c   = a[7];
            end
            OP_SHR: begin
                alu_res = {1'b0, a[7:1]};
                alu_c   = a[0];
            end
            OP_ASR: begin
                alu_res = {a[7], a[7:1]};
                alu_c   = a[0];
            end
            OP_MUL: wr_res = 1'b0;
            default: begin
                legal  = 1'b0;
                wr_res = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            res_q     <= '0;
            hi_q      <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.aluOp == OP_MUL) begin
                            state_q  <= S_MUL;
                            busy_q   <= 1'b1;
                            acc_q    <= '0;
                            mcand_q  <= {8'h00, a};
                            mplier_q <= b;
                            cnt_q    <= '0;
                        end else begin
                            done_q <= 1'b1;
                            if (!legal) begin
                                illegal_q <= 1'b1;
                            end else begin
                                if (wr_res) res_q <= alu_res;
                                z_q <= (alu_res == 8'h00);
                                n_q <= alu_res[7];
                                c_q <= alu_c;
                                v_q <= alu_v;
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= acc_d[7:0];
                        hi_q    <= acc_d[15:8];
                        z_q     <= (acc_d == 16'h0000);
                        n_q     <= acc_d[15];
                        c_q     <= |acc_d[15:8];
                        v_q     <= |acc_d[15:8];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;
    assign bus.result   = res_q;
    assign bus.resultHi = hi_q;
    assign bus.flagZ    = z_q;
    assign bus.flagN    = n_q;
    assign bus.flagC    = c_q;
    assign bus.flagV    = v_q;
endmodule
